// File: rtl/bitrev_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bitrev_frame_ctrl                                               |
// | Brief    : Job controller gating a sample stream into and out of a         |
// |            bit-reversal core, counting 2^K-sample frames per job.          |
// |            Optional macro BITREV_FRAME_CTRL_IRQ_EN adds a sticky irq_o.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bitrev_frame_ctrl #(
   parameter int K  = 10,
   parameter int DW = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [15:0]     num_frames_i,
   output logic            busy_o,
   output logic            done_o,
   input  logic            src_valid_i,
   input  logic [DW-1:0]   src_data_i,
   output logic            src_ready_o,
   output logic            core_valid_o,
   output logic [DW-1:0]   core_data_o,
   input  logic            core_ready_i,
   input  logic            core_valid_i,
   input  logic [DW-1:0]   core_data_i,
   output logic            core_ready_o,
   output logic            snk_valid_o,
   output logic [DW-1:0]   snk_data_o,
   input  logic            snk_ready_i,
   output logic [16+K-1:0] in_cnt_o,
   output logic [16+K-1:0] out_cnt_o
`ifdef BITREV_FRAME_CTRL_IRQ_EN
   ,
   input  logic            irq_clr_i,
   output logic            irq_o
`endif
);

   localparam int              c_cnt_w = 16 + K;
   localparam logic [c_cnt_w-1:0] c_one = {{(c_cnt_w-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_cnt_w-1:0]   r_total;
   logic [c_cnt_w-1:0]   r_in_cnt;
   logic [c_cnt_w-1:0]   r_out_cnt;

   logic w_gate_in;
   logic w_gate_out;
   logic w_in_hs;
   logic w_out_hs;
   logic w_in_last;
   logic w_out_last;
   logic w_start_acc;

   assign w_gate_in   = (r_state == S_RUN);
   assign w_gate_out  = (r_state == S_RUN) || (r_state == S_DRAIN);

   // Both paths are pure wires through the gates: zero latency, no storage.
   assign core_valid_o = src_valid_i & w_gate_in;
   assign src_ready_o  = core_ready_i & w_gate_in;
   assign core_data_o  = src_data_i;
   assign snk_valid_o  = core_valid_i & w_gate_out;
   assign core_ready_o = snk_ready_i & w_gate_out;
   assign snk_data_o   = core_data_i;

   assign w_in_hs     = core_valid_o & core_ready_i;
   assign w_out_hs    = snk_valid_o & snk_ready_i;
   assign w_in_last   = w_in_hs && ((r_in_cnt + c_one) == r_total);
   assign w_out_last  = w_out_hs && ((r_out_cnt + c_one) == r_total);
   assign w_start_acc = (r_state == S_IDLE) && start_i;

   assign busy_o   = w_gate_out;
   assign done_o   = (r_state == S_DONE);
   assign in_cnt_o  = r_in_cnt;
   assign out_cnt_o = r_out_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt = (num_frames_i != 16'd0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            // Abort outranks any completion decided in the same cycle.
            if (abort_i) begin
               w_state_nxt = S_IDLE;
            end else if (w_in_last && (w_out_last || (r_out_cnt == r_total))) begin
               w_state_nxt = S_DONE;
            end else if (w_in_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort_i) begin
               w_state_nxt = S_IDLE;
            end else if (w_out_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_total   <= '0;
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
      end else if (w_start_acc) begin
         r_total   <= {num_frames_i, {K{1'b0}}};
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
      end else begin
         if (w_in_hs) begin
            r_in_cnt <= r_in_cnt + c_one;
         end
         if (w_out_hs) begin
            r_out_cnt <= r_out_cnt + c_one;
         end
      end
   end

`ifdef BITREV_FRAME_CTRL_IRQ_EN
   logic r_irq;

   // Set has priority so a clear coinciding with done never loses the event.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_irq <= 1'b0;
      end else if (done_o) begin
         r_irq <= 1'b1;
      end else if (irq_clr_i) begin
         r_irq <= 1'b0;
      end
   end

   assign irq_o = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitrev_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bitrev_frame_ctrl                                            |
// | Brief    : Self-checking bench for bitrev_frame_ctrl (K=3) with a          |
// |            behavioural job model, stand-in core and data scoreboard.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_bitrev_frame_ctrl;

   localparam int K  = 3;
   localparam int DW = 16;
   localparam int CW = 16 + K;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, abort;
   logic [15:0]   num_frames;
   logic          src_valid, snk_ready, core_rdy_rand, loop_mode;
   logic [DW-1:0] src_data;

   logic          busy_o, done_o, src_ready_o, core_valid_o, core_ready_o, snk_valid_o;
   logic [DW-1:0] core_data_o, snk_data_o;
   logic [CW-1:0] in_cnt_o, out_cnt_o;
   logic          core_valid_in, core_ready_in;
   logic [DW-1:0] core_data_in;
`ifdef BITREV_FRAME_CTRL_IRQ_EN
   logic          irq_clr;
   logic          irq_o;
   bit            m_irq;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int done_seen = 0;

   // stand-in core: either a direct wire loop or an in-order FIFO
   logic [DW-1:0] mem [0:255];
   int            wp = 0;
   int            rp = 0;
   bit            m_flush = 1'b0;

   // behavioural model of the job
   bit            m_job, m_done;
   int            m_total, m_in, m_out;
   logic [DW-1:0] sb [$];

   always #5 clk = ~clk;

   assign core_valid_in = loop_mode ? core_valid_o : (wp != rp);
   assign core_data_in  = loop_mode ? core_data_o  : mem[rp[7:0]];
   assign core_ready_in = loop_mode ? core_ready_o : core_rdy_rand;

   bitrev_frame_ctrl #(.K(K), .DW(DW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .abort_i      (abort),
      .num_frames_i (num_frames),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .src_valid_i  (src_valid),
      .src_data_i   (src_data),
      .src_ready_o  (src_ready_o),
      .core_valid_o (core_valid_o),
      .core_data_o  (core_data_o),
      .core_ready_i (core_ready_in),
      .core_valid_i (core_valid_in),
      .core_data_i  (core_data_in),
      .core_ready_o (core_ready_o),
      .snk_valid_o  (snk_valid_o),
      .snk_data_o   (snk_data_o),
      .snk_ready_i  (snk_ready),
      .in_cnt_o     (in_cnt_o),
      .out_cnt_o    (out_cnt_o)
`ifdef BITREV_FRAME_CTRL_IRQ_EN
      ,
      .irq_clr_i    (irq_clr),
      .irq_o        (irq_o)
`endif
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (m_flush) begin
         rp <= wp;
      end else if (!loop_mode) begin
         if (core_valid_o && core_ready_in) begin
            mem[wp[7:0]] <= core_data_o;
            wp <= wp + 1;
         end
         if (core_valid_in && core_ready_o) begin
            rp <= rp + 1;
         end
      end
   end

   // Compare process: outputs are settled at the falling edge.
   always @(negedge clk) begin
      bit gi, go, e_cv, e_cr, e_sr, e_sv, eff_cri, eff_cvi, hs_in, hs_out;
      logic [DW-1:0] eff_cdi;
      m_flush <= 1'b0;
      if (!rst_n) begin
         m_job = 0; m_done = 0; m_in = 0; m_out = 0; m_total = 0;
         sb.delete();
         chk("rst_busy", busy_o, 0);
         chk("rst_done", done_o, 0);
         chk("rst_src_ready", src_ready_o, 0);
         chk("rst_core_valid", core_valid_o, 0);
         chk("rst_core_ready", core_ready_o, 0);
         chk("rst_snk_valid", snk_valid_o, 0);
         chk("rst_in_cnt", in_cnt_o, 0);
         chk("rst_out_cnt", out_cnt_o, 0);
`ifdef BITREV_FRAME_CTRL_IRQ_EN
         m_irq = 0;
         chk("rst_irq", irq_o, 0);
`endif
      end else begin
         gi      = m_job && (m_in < m_total);
         go      = m_job;
         e_cv    = src_valid && gi;
         e_cr    = snk_ready && go;
         eff_cri = loop_mode ? e_cr : core_rdy_rand;
         e_sr    = eff_cri && gi;
         eff_cvi = loop_mode ? e_cv : (wp != rp);
         eff_cdi = loop_mode ? src_data : mem[rp[7:0]];
         e_sv    = eff_cvi && go;
         chk("busy", busy_o, m_job);
         chk("done", done_o, m_done);
         chk("core_valid", core_valid_o, e_cv);
         chk("src_ready", src_ready_o, e_sr);
         chk("core_ready", core_ready_o, e_cr);
         chk("snk_valid", snk_valid_o, e_sv);
         chk("in_cnt", in_cnt_o, m_in);
         chk("out_cnt", out_cnt_o, m_out);
         if (e_cv) chk("core_data", core_data_o, src_data);
         if (e_sv) chk("snk_data", snk_data_o, eff_cdi);
`ifdef BITREV_FRAME_CTRL_IRQ_EN
         chk("irq", irq_o, m_irq);
         if (m_done) m_irq = 1;
         else if (irq_clr) m_irq = 0;
`endif
         hs_in  = e_cv && eff_cri;
         hs_out = e_sv && snk_ready;
         if (hs_in) sb.push_back(src_data);
         if (hs_out) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL snk_order: got %0h expected no output at %0t", snk_data_o, $time);
            end else begin
               chk("snk_order", snk_data_o, sb.pop_front());
            end
         end
         if (done_o) done_seen++;
         if (m_done) begin
            m_done = 0;
         end else if (!m_job) begin
            if (start) begin
               m_in = 0; m_out = 0;
               m_total = int'(num_frames) * (1 << K);
               sb.delete();
               m_flush <= 1'b1;
               if (num_frames == 0) m_done = 1;
               else m_job = 1;
            end
         end else begin
            m_in  += int'(hs_in);
            m_out += int'(hs_out);
            if (abort) m_job = 0;
            else if (m_in == m_total && m_out == m_total) begin
               m_job = 0;
               m_done = 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int bound, input string nm);
      int i;
      for (i = 0; i < bound; i++) begin
         tick();
         if (!busy_o && !done_o) break;
      end
      if (i == bound) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got timeout expected idle within %0d cycles", nm, bound);
      end
   endtask

   task automatic wait_in(input int val, input int bound, input string nm);
      int i;
      for (i = 0; i < bound; i++) begin
         if (int'(in_cnt_o) == val) break;
         tick();
      end
      if (i == bound) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got in_cnt %0d expected %0d", nm, in_cnt_o, val);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      start = 0; abort = 0; num_frames = 0; src_valid = 1; src_data = 16'h1234;
      snk_ready = 1; core_rdy_rand = 1; loop_mode = 1;
`ifdef BITREV_FRAME_CTRL_IRQ_EN
      irq_clr = 0;
`endif
      rst_n = 1;
      #2 rst_n = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      chk("post_rst_busy", busy_o, 0);
      chk("post_rst_in_cnt", in_cnt_o, 0);

      // zero-frame job: done one cycle later, never busy, no handshakes
      d0 = done_seen;
      start = 1; num_frames = 0;
      tick();
      start = 0;
      chk("zero_done", done_o, 1);
      chk("zero_busy", busy_o, 0);
      chk("zero_src_ready", src_ready_o, 0);
      tick();
      chk("zero_done_end", done_o, 0);
      chk("zero_busy_end", busy_o, 0);
      chk("zero_pulses", done_seen - d0, 1);

      // two frames through the wire loop, everything always ready
      d0 = done_seen;
      src_data = 16'hA5A5;
      start = 1; num_frames = 2;
      tick();
      start = 0;
      chk("t2_busy", busy_o, 1);
      wait_idle(100, "t2_wait");
      chk("t2_in_cnt", in_cnt_o, 16);
      chk("t2_out_cnt", out_cnt_o, 16);
      chk("t2_pulses", done_seen - d0, 1);

      // abort after 5 inputs; a restart during RUN is ignored
      d0 = done_seen;
      start = 1; num_frames = 2;
      tick();
      start = 0;
      wait_in(3, 50, "t4_wait3");
      start = 1; num_frames = 3;
      tick();
      start = 0;
      wait_in(5, 50, "t4_wait5");
      src_valid = 0; abort = 1;
      tick();
      abort = 0; src_valid = 1;
      chk("t4_busy", busy_o, 0);
      chk("t4_src_ready", src_ready_o, 0);
      chk("t4_in_cnt", in_cnt_o, 5);
      repeat (4) tick();
      chk("t4_in_hold", in_cnt_o, 5);
      chk("t4_no_done", done_seen - d0, 0);

      // one frame with the sink stalled until all input is taken
      loop_mode = 0; snk_ready = 0; core_rdy_rand = 1;
      tick();
      d0 = done_seen;
      start = 1; num_frames = 1;
      tick();
      start = 0;
      wait_in(8, 50, "t3_wait_in");
      chk("t3_drain_busy", busy_o, 1);
      chk("t3_drain_out", out_cnt_o, 0);
      chk("t3_drain_src_ready", src_ready_o, 0);
      snk_ready = 1;
      wait_idle(50, "t3_wait");
      chk("t3_out_cnt", out_cnt_o, 8);
      chk("t3_pulses", done_seen - d0, 1);

      // randomized traffic, FIFO core then wire loop
      d0 = done_seen;
      for (int seg = 0; seg < 2; seg++) begin
         loop_mode = (seg == 1);
         for (int c = 0; c < 1500; c++) begin
            src_valid     = ($urandom_range(0, 3) != 0);
            src_data      = 16'($urandom);
            snk_ready     = ($urandom_range(0, 3) != 0);
            core_rdy_rand = ($urandom_range(0, 3) != 0);
            start         = ($urandom_range(0, 15) == 0);
            num_frames    = 16'($urandom_range(1, 3));
            abort         = ($urandom_range(0, 199) == 0);
            tick();
         end
         start = 0; abort = 0; snk_ready = 1; src_valid = 1; core_rdy_rand = 1;
         wait_idle(500, "rand_drain");
      end
      chk("rand_jobs_done", (done_seen - d0) > 10, 1);

      // reset in the middle of a job
      loop_mode = 1;
      start = 1; num_frames = 1;
      tick();
      start = 0;
      repeat (2) tick();
      rst_n = 0;
      #1;
      chk("midrst_busy", busy_o, 0);
      chk("midrst_in_cnt", in_cnt_o, 0);
      chk("midrst_src_ready", src_ready_o, 0);
      @(posedge clk);
      #1 rst_n = 1;
      tick();
      chk("midrst_idle", busy_o, 0);

`ifdef BITREV_FRAME_CTRL_IRQ_EN
      start = 1; num_frames = 1;
      tick();
      start = 0;
      wait_idle(50, "irq_job");
      chk("irq_set", irq_o, 1);
      irq_clr = 1;
      tick();
      irq_clr = 0;
      chk("irq_cleared", irq_o, 0);
      start = 1; num_frames = 1;
      tick();
      start = 0;
      for (int i = 0; i < 50 && !done_o; i++) tick();
      irq_clr = 1;
      tick();
      irq_clr = 0;
      chk("irq_set_wins", irq_o, 1);
`endif

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
